// File: rtl/ub_activation_fetcher.sv
// Unified Buffer activation read master: strided command -> UB reads -> credit-limited FIFO -> valid/ready stream.
// Define UB_FETCH_STALL_CNT_EN to add the StallCycles backpressure counter output.
module ub_activation_fetcher #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_BANKS    = 16,
    parameter int BANK_DEPTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4,
    localparam int BANK_BITS   = $clog2(NUM_BANKS),
    localparam int ROW_BITS    = $clog2(BANK_DEPTH),
    localparam int ADDR_WIDTH  = BANK_BITS + ROW_BITS
) (
    input  logic                         CLK,
    input  logic                         ASYNC_RST,
    input  logic                         SYNC_RST,
    input  logic                         EN,
    input  logic                         StartValid,
    output logic                         StartReady,
    input  logic [ADDR_WIDTH-1:0]        StartBase,
    input  logic [ADDR_WIDTH-1:0]        StartStride,
    input  logic [ADDR_WIDTH:0]          StartLength,
    output logic                         ActivationReadValid,
    output logic [ADDR_WIDTH-1:0]        ActivationReadAddress,
    input  logic signed [DATA_WIDTH-1:0] ActivationReadData,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic signed [DATA_WIDTH-1:0] OutData,
    output logic                         OutLast,
    output logic                         Busy,
`ifdef UB_FETCH_STALL_CNT_EN
    output logic [15:0]                  StallCycles,
`endif
    output logic                         Done
);

    // state | meaning
    // IDLE  | waiting for a command, StartReady high
    // FETCH | issuing reads while FIFO credit allows
    // DRAIN | all reads issued, waiting for returns and FIFO to empty
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   stride;
    logic [ADDR_WIDTH-1:0]   curAddr;
    logic [LEN_W-1:0]        length;
    logic [LEN_W-1:0]        issued;
    logic [LEN_W-1:0]        returned;
    logic [LEN_W-1:0]        returnedNext;
    logic [READ_LATENCY-1:0] validPipe;
    logic [DATA_WIDTH-1:0]   fifoData [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifoLast;
    logic [PTR_W-1:0]        wrPtr;
    logic [PTR_W-1:0]        rdPtr;
    logic [CNT_W-1:0]        fifoCount;
    logic [CNT_W-1:0]        countNext;
    logic [CNT_W-1:0]        inflight;
    logic                    accept;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    drained;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++)
            inflight = inflight + CNT_W'(validPipe[i]);
    end

    // Credit uses pre-pop occupancy so a same-cycle pop never over-commits the FIFO.
    assign accept  = EN && !SYNC_RST && (state == IDLE) && StartValid;
    assign issue   = EN && !SYNC_RST && (state == FETCH) && (issued < length)
                     && ((fifoCount + inflight) < CNT_W'(FIFO_DEPTH));
    assign push    = EN && validPipe[READ_LATENCY-1];
    assign pop     = EN && OutValid && OutReady;

    assign countNext    = fifoCount + CNT_W'(push) - CNT_W'(pop);
    assign returnedNext = returned + LEN_W'(push);
    assign drained      = (returnedNext == length) && (countNext == '0);

    assign StartReady            = (state == IDLE);
    assign Busy                  = (state != IDLE);
    assign Done                  = (state == DONE);
    assign OutValid              = (fifoCount != '0);
    assign OutData               = OutValid ? fifoData[rdPtr] : '0;
    assign OutLast               = OutValid && fifoLast[rdPtr];
    assign ActivationReadValid   = issue;
    assign ActivationReadAddress = curAddr;

    always_ff @(posedge CLK) begin
        if (push && !SYNC_RST) begin
            fifoData[wrPtr] <= ActivationReadData;
            fifoLast[wrPtr] <= ((returned + LEN_W'(1)) == length);
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state     <= IDLE;
            stride    <= '0;
            curAddr   <= '0;
            length    <= '0;
            issued    <= '0;
            returned  <= '0;
            validPipe <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else if (SYNC_RST) begin
            state     <= IDLE;
            stride    <= '0;
            curAddr   <= '0;
            length    <= '0;
            issued    <= '0;
            returned  <= '0;
            validPipe <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else if (EN) begin
            for (int i = READ_LATENCY - 1; i > 0; i--)
                validPipe[i] <= validPipe[i-1];
            validPipe[0] <= issue;
            if (push)
                wrPtr <= wrPtr + PTR_W'(1);
            if (pop)
                rdPtr <= rdPtr + PTR_W'(1);
            fifoCount <= countNext;
            returned  <= returnedNext;
            if (issue) begin
                issued  <= issued + LEN_W'(1);
                curAddr <= curAddr + stride;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        stride   <= StartStride;
                        curAddr  <= StartBase;
                        length   <= StartLength;
                        issued   <= '0;
                        returned <= '0;
                        state    <= (StartLength == '0) ? DONE : FETCH;
                    end
                end
                FETCH:   if (issued == length) state <= DRAIN;
                DRAIN:   if (drained) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UB_FETCH_STALL_CNT_EN
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST)
            StallCycles <= '0;
        else if (SYNC_RST || accept)
            StallCycles <= '0;
        else if (EN && OutValid && !OutReady && (StallCycles != 16'hFFFF))
            StallCycles <= StallCycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ub_activation_fetcher.sv
// Randomized bench for ub_activation_fetcher: a UB memory model plus a queue-based
// reference of expected read addresses and output words per command.
module tb_ub_activation_fetcher;

    localparam int FIFO_DEPTH = 4;
    localparam int NONE       = 1000;

    logic        CLK = 1'b0;
    logic        ASYNC_RST;
    logic        SYNC_RST;
    logic        EN;
    logic        StartValid;
    logic        StartReady;
    logic [7:0]  StartBase;
    logic [7:0]  StartStride;
    logic [8:0]  StartLength;
    logic        ActivationReadValid;
    logic [7:0]  ActivationReadAddress;
    logic [7:0]  ActivationReadData;
    logic        OutValid;
    logic        OutReady;
    logic [7:0]  OutData;
    logic        OutLast;
    logic        Busy;
    logic        Done;

    ub_activation_fetcher dut (
        .CLK                  (CLK),
        .ASYNC_RST            (ASYNC_RST),
        .SYNC_RST             (SYNC_RST),
        .EN                   (EN),
        .StartValid           (StartValid),
        .StartReady           (StartReady),
        .StartBase            (StartBase),
        .StartStride          (StartStride),
        .StartLength          (StartLength),
        .ActivationReadValid  (ActivationReadValid),
        .ActivationReadAddress(ActivationReadAddress),
        .ActivationReadData   (ActivationReadData),
        .OutValid             (OutValid),
        .OutReady             (OutReady),
        .OutData              (OutData),
        .OutLast              (OutLast),
        .Busy                 (Busy),
        .Done                 (Done)
    );

    always #5 CLK = ~CLK;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // One-cycle-latency UB model, frozen by the shared EN.
    logic [7:0] ubMem [256];
    logic [7:0] ubRdData = 8'h00;
    always @(posedge CLK) if (EN && ActivationReadValid) ubRdData <= ubMem[ActivationReadAddress];
    assign ActivationReadData = ubRdData;

    int expAddr[$];
    int expData[$];   // bit 8 = last flag, bits 7:0 = word
    int readsSeen, wordsSeen, cmdReads, cmdWords, curLen;
    int firstReadCycle, lastReadCycle, firstPopCycle, lastPopCycle, acceptCycle;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    always @(negedge CLK) begin
        int v;
        if (ASYNC_RST && !SYNC_RST && EN) begin
            if (ActivationReadValid) begin
                checkValue("creditLimit", 32'((readsSeen - wordsSeen) < FIFO_DEPTH), 1);
                checkValue("readExpected", 32'(expAddr.size() > 0), 1);
                if (expAddr.size() > 0) checkValue("readAddr", ActivationReadAddress, expAddr.pop_front());
                if (cmdReads == 0) firstReadCycle = cyc;
                lastReadCycle = cyc;
                cmdReads++;
                readsSeen++;
            end
            if (OutValid && OutReady) begin
                checkValue("wordExpected", 32'(expData.size() > 0), 1);
                if (expData.size() > 0) begin
                    v = expData.pop_front();
                    checkValue("outData", OutData, v & 32'hFF);
                    checkValue("outLast", OutLast, (v >> 8) & 1);
                end
                if (cmdWords == 0) firstPopCycle = cyc;
                lastPopCycle = cyc;
                cmdWords++;
                wordsSeen++;
            end
        end
    end

    task automatic startCmd(input logic [7:0] base, input logic [7:0] stride, input int len, input int holdCycles);
        logic [7:0] a;
        cmdReads = 0;
        cmdWords = 0;
        curLen   = len;
        firstReadCycle = -1; lastReadCycle = -1; firstPopCycle = -1; lastPopCycle = -1;
        for (int i = 0; i < len; i++) begin
            a = 8'(int'(base) + i * int'(stride));
            expAddr.push_back(int'(a));
            expData.push_back(((i == len - 1) ? 256 : 0) + int'(ubMem[a]));
        end
        @(posedge CLK); #1;
        checkValue("startReadyIdle", StartReady, 1);
        StartValid  = 1'b1;
        StartBase   = base;
        StartStride = stride;
        StartLength = 9'(len);
        OutReady    = (holdCycles == 0);
        acceptCycle = cyc;
        @(posedge CLK); #1;
        StartValid  = 1'b0;
    endtask

    task automatic finishCmd(input int holdCycles, input int readyPct, input int pulseAt, input int enOffAt);
        bit doneSeen  = 0;
        bit pulsed    = 0;
        int doneCycle = -1;
        int readsAtHold = -1;
        for (int c = 0; c < 600 && !doneSeen; c++) begin
            @(negedge CLK);
            if (pulsed) begin
                checkValue("startReadyWhileBusy", StartReady, 0);
                pulsed = 0;
            end
            if (!EN) checkValue("readWhileDisabled", ActivationReadValid, 0);
            if (c == holdCycles) readsAtHold = cmdReads;
            if (Done) begin
                doneSeen  = 1;
                doneCycle = cyc;
            end else begin
                @(posedge CLK); #1;
                OutReady   = (c + 1 >= holdCycles) && ($urandom_range(1, 100) <= readyPct);
                EN         = !(c >= enOffAt && c < enOffAt + 3);
                StartValid = (c == pulseAt);
                if (c == pulseAt) begin
                    StartBase = 8'($urandom);
                    pulsed    = 1;
                end
            end
        end
        checkValue("doneSeen", doneSeen, 1);
        checkValue("readCount", cmdReads, curLen);
        checkValue("wordCount", cmdWords, curLen);
        checkValue("leftoverWords", expData.size(), 0);
        if (curLen > 0) begin
            checkValue("firstReadLatency", firstReadCycle, acceptCycle + 1);
            checkValue("doneAfterLast", doneCycle, lastPopCycle + 1);
        end else begin
            checkValue("doneAfterLen0", doneCycle, acceptCycle + 1);
        end
        if (holdCycles > 0) checkValue("readsDuringHold", readsAtHold, FIFO_DEPTH);
        @(posedge CLK); #1;
        EN = 1'b1;
        OutReady = 1'b1;
        StartValid = 1'b0;
        @(negedge CLK);
        checkValue("donePulseWidth", Done, 0);
        checkValue("idleStartReady", StartReady, 1);
        checkValue("idleBusy", Busy, 0);
    endtask

    initial begin
        ASYNC_RST = 1'b0; SYNC_RST = 1'b0; EN = 1'b1; StartValid = 1'b0;
        StartBase = '0; StartStride = '0; StartLength = '0; OutReady = 1'b0;
        readsSeen = 0; wordsSeen = 0; cmdReads = 0; cmdWords = 0; curLen = 0;
        for (int i = 0; i < 256; i++) ubMem[i] = 8'($urandom);
        ubMem[8'h10] = 8'd1; ubMem[8'h11] = 8'd2; ubMem[8'h12] = 8'd3; ubMem[8'h13] = 8'hFC;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkValue("rstStartReady", StartReady, 1);
        checkValue("rstBusy", Busy, 0);
        checkValue("rstDone", Done, 0);
        checkValue("rstOutValid", OutValid, 0);
        checkValue("rstReadValid", ActivationReadValid, 0);
        checkValue("rstOutLast", OutLast, 0);
        checkValue("rstOutData", OutData, 0);
        @(posedge CLK); #1;
        ASYNC_RST = 1'b1;

        // Preloaded 1,2,3,-4 with full throughput.
        startCmd(8'h10, 8'h01, 4, 0);
        finishCmd(0, 100, -1, NONE);
        checkValue("lastReadCycle", lastReadCycle, acceptCycle + 4);
        checkValue("firstPopCycle", firstPopCycle, acceptCycle + 3);
        checkValue("lastPopCycle", lastPopCycle, acceptCycle + 6);

        // Backpressure: only FIFO_DEPTH reads may be outstanding.
        startCmd(8'h10, 8'h01, 8, 10);
        finishCmd(10, 100, -1, NONE);

        // Address wrap: 0xFE, 0x0F, 0x20.
        startCmd(8'hFE, 8'h11, 3, 0);
        finishCmd(0, 100, -1, NONE);

        // Zero-length command.
        startCmd(8'h33, 8'h05, 0, 0);
        finishCmd(0, 100, -1, NONE);

        // Synchronous clear after two of six words.
        startCmd(8'h40, 8'h03, 6, 0);
        for (int c = 0; c < 50 && cmdWords < 2; c++) @(negedge CLK);
        checkValue("twoWordsBeforeClear", cmdWords, 2);
        @(posedge CLK); #1;
        SYNC_RST = 1'b1;
        expAddr.delete();
        expData.delete();
        readsSeen = 0;
        wordsSeen = 0;
        @(negedge CLK);
        checkValue("readDuringClear", ActivationReadValid, 0);
        @(posedge CLK); #1;
        SYNC_RST = 1'b0;
        @(negedge CLK);
        checkValue("clearOutValid", OutValid, 0);
        checkValue("clearBusy", Busy, 0);
        checkValue("clearStartReady", StartReady, 1);
        repeat (2) @(negedge CLK);
        checkValue("clearNoLateWord", OutValid, 0);
        startCmd(8'h90, 8'h07, 2, 0);
        finishCmd(0, 100, -1, NONE);

        // Start pulse while busy must be ignored.
        startCmd(8'h20, 8'h02, 6, 0);
        finishCmd(0, 50, 2, NONE);

        // EN low for three cycles mid-fetch.
        startCmd(8'h80, 8'h01, 8, 0);
        finishCmd(0, 100, -1, 2);

        for (int t = 0; t < 25; t++) begin
            int len;
            int pct;
            int pAt;
            int eAt;
            len = $urandom_range(0, 12);
            pct = (t % 3 == 0) ? 100 : $urandom_range(25, 90);
            pAt = (len >= 6 && (t % 2 == 1)) ? 2 : -1;
            eAt = (len >= 6 && (t % 3 == 1)) ? 1 : NONE;
            startCmd(8'($urandom), 8'($urandom), len, 0);
            finishCmd(0, pct, pAt, eAt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
